qpsk_rx_deframer: RTL and testbench

Receive-side counterpart of the TX chain (QPSK mapper → header insertion → 8-cycle sample hold). Takes the 24-bit I/Q sample stream from the front end and decimates it by DECIM, picking one sample per symbol. It hard-decides each QPSK symbol to a bit pair, hunts for the fixed frame header, then emits PAYLOAD_LEN payload bit pairs per frame with a last flag. Sits between the RX sample source and the bit sink, mirroring the TX path top.

---
 rtl/rx_pkg.sv | 19 +
 rtl/hdr_correlator.sv | 79 +++++++
 rtl/qpsk_rx_deframer.sv | 147 ++++++++++++++
 tb/tb_qpsk_rx_deframer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rx_pkg -- shared definitions for the QPSK receive deframer.
//
// Holds the deframer state encoding, the per-component sample width and the
// default frame header. The header is HDR_LEN_DEF symbols wide at two bits per symbol.
// Symbol k sits in bits [2k+1:2k], with I in the MSB and Q in the LSB.
// Symbol 0 is the first one on the air.
package rx_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_e;

  localparam int SAMPLE_W = 12;

  localparam int          HDR_LEN_DEF     = 16;
  localparam logic [31:0] HDR_PATTERN_DEF = 32'hF3A0_5C96;

endpackage

// File: rtl/hdr_correlator.sv
// hdr_correlator -- header shift register and match detector.
//
// Each cycle with shift high, the decided symbol is shifted into a
// 2*HDR_LEN-bit register. The newest symbol goes into the LSB pair, so once a
// full header has arrived, symbol 0 sits in the MSB pair. The match is taken on
// the value being shifted in. The match pulse therefore lines up with the
// decision of the final header symbol, and the very next decision can be
// payload.
//
// Build option: define RX_HDR_TOL_EN to accept a header that is within a
// Hamming distance of 1 bit of HDR_PATTERN. Without it, only an exact match is
// accepted.
//
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   shift  in   shift sym into the register this cycle
//   sym    in   [1] = I bit, [0] = Q bit
//   clear  in   zero the register (takes priority over shift)
//   match  out  one-cycle pulse, combinational with shift
//
// HDR_LEN must be at least 2.
module hdr_correlator
  import rx_pkg::*;
#(
  parameter int                    HDR_LEN     = HDR_LEN_DEF,
  parameter logic [2*HDR_LEN-1:0]  HDR_PATTERN = HDR_PATTERN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift,
  input  logic [1:0] sym,
  input  logic       clear,
  output logic       match
);

  localparam int             W   = 2 * HDR_LEN;
  localparam logic [W-1:0]   ONE = W'(1);

  logic [W-1:0] sr;
  logic [W-1:0] sr_next;
  logic [W-1:0] ref_pattern;
  logic [W-1:0] diff;
  logic         hit;

  // The pattern lists symbol 0 in the LSB pair, but the register holds it in
  // the MSB pair. Reverse the pair order once so the two line up.
  always_comb begin
    ref_pattern = '0;
    for (int k = 0; k < HDR_LEN; k++) begin
      ref_pattern[2*(HDR_LEN-1-k) +: 2] = HDR_PATTERN[2*k +: 2];
    end
  end

  assign sr_next = {sr[W-3:0], sym};
  assign diff    = sr_next ^ ref_pattern;

`ifdef RX_HDR_TOL_EN
  // Clearing the lowest set bit leaves zero only when at most one bit differs.
  assign hit = ((diff & (diff - ONE)) == '0);
`else
  assign hit = (diff == '0);
  logic unused_one;
  assign unused_one = ONE[0];
`endif

  assign match = shift & hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift) begin
      sr <= sr_next;
    end
  end

endmodule

// File: rtl/qpsk_rx_deframer.sv
// qpsk_rx_deframer -- QPSK receive decimator, hard demapper and deframer.
//
// Accepts 24-bit I/Q samples. It keeps one sample in DECIM: the one at phase
// SAMPLE_PHASE. That sample is hard-decided on its sign bits and fed to the
// header correlator. After a header match, it emits PAYLOAD_LEN bit pairs,
// flagging the last one.
//
// Build option: RX_HDR_TOL_EN (see hdr_correlator) enables a header match
// that tolerates one bit error.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   sample valid
//   in_data    in   [23:12] I, [11:0] Q, two's complement
//   in_ready   out  sample ready
//   out_valid  out  payload symbol valid
//   out_ready  in  sink ready
//   out_i      out  I bit
//   out_q      out  Q bit
//   out_last   out  high with the final payload symbol of a frame
//   locked     out  high while in PAYLOAD
//   dbg_state  out  current FSM state
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. The output register holds out_valid/out_i/out_q/out_last steady
// while out_valid & ~out_ready. in_ready = ~out_valid | out_ready. As a result,
// a new decision can only load the register once the previous symbol is
// leaving or has already left.
module qpsk_rx_deframer
  import rx_pkg::*;
#(
  parameter int                    DECIM        = 8,
  parameter int                    SAMPLE_PHASE = 4,
  parameter int                    HDR_LEN      = HDR_LEN_DEF,
  parameter logic [2*HDR_LEN-1:0]  HDR_PATTERN  = HDR_PATTERN_DEF,
  parameter int                    PAYLOAD_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2*SAMPLE_W-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_i,
  output logic                  out_q,
  output logic                  out_last,
  output logic                  locked,
  output rx_state_e             dbg_state
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CNT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

  rx_state_e        state_q, state_d;
  logic [PH_W-1:0]  ph;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             decide;
  logic             sym_i, sym_q;
  logic             match;
  logic             last_sym;
  logic             hdr_shift;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign decide   = accept & (ph == PH_W'(SAMPLE_PHASE));

  // Sign bit is the decision: positive (or zero) -> 0, negative -> 1.
  assign sym_i = in_data[2*SAMPLE_W-1];
  assign sym_q = in_data[SAMPLE_W-1];

  logic unused_bits;
  assign unused_bits = ^{in_data[2*SAMPLE_W-2:SAMPLE_W], in_data[SAMPLE_W-2:0]};

  assign hdr_shift = decide & (state_q == HUNT);
  assign last_sym  = decide & (state_q == PAYLOAD) &
                     (cnt == CNT_W'(PAYLOAD_LEN - 1));

  hdr_correlator #(
    .HDR_LEN     (HDR_LEN),
    .HDR_PATTERN (HDR_PATTERN)
  ) u_corr (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (hdr_shift),
    .sym   ({sym_i, sym_q}),
    .clear (last_sym),
    .match (match)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (match)    state_d = PAYLOAD;
      PAYLOAD: if (last_sym) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  assign locked    = (state_q == PAYLOAD);
  assign dbg_state = state_q;

  // Sample phase, payload counter and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_i     <= 1'b0;
      out_q     <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        ph <= (ph == PH_W'(DECIM - 1)) ? '0 : ph + PH_W'(1);
      end

      if (match) begin
        cnt <= '0;
      end else if (decide && state_q == PAYLOAD) begin
        cnt <= last_sym ? '0 : cnt + CNT_W'(1);
      end

      if (decide && state_q == PAYLOAD) begin
        out_valid <= 1'b1;
        out_i     <= sym_i;
        out_q     <= sym_q;
        out_last  <= last_sym;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_rx_deframer.sv
// tb_qpsk_rx_deframer -- directed bench for qpsk_rx_deframer.
module tb_qpsk_rx_deframer;
  import rx_pkg::*;

  localparam int          DECIM = 8;
  localparam int          SP    = 4;
  localparam int          HL    = 16;
  localparam int          PL    = 256;
  localparam logic [31:0] HDR   = 32'hF3A0_5C96;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_i;
  logic        out_q;
  logic        out_last;
  logic        locked;
  rx_state_e   dbg_state;

  qpsk_rx_deframer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_last  (out_last),
    .locked    (locked),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int         checks = 0;
  int         errors = 0;
  int         out_count = 0;
  int         last_count = 0;
  logic [2:0] exp_q[$];          // {i, q, last}

  bit         stall_mode = 0;
  int         stall_idx = 0;
  logic [3:0] stall_pat = 4'b1001;

  bit         prev_stall = 0;
  logic [2:0] prev_out = '0;

  typedef struct {
    logic [11:0] i_val;
    logic [11:0] q_val;
    logic        exp_i;
    logic        exp_q;
  } demap_vec_t;

  demap_vec_t vecs[8];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [11:0] lvl(input logic b);
    return b ? 12'hC18 : 12'h3E8;   // -1000 : +1000
  endfunction

  // ---------------- out_ready pattern driver ----------------
  always @(posedge clk) begin
    if (stall_mode) begin
      #1;
      out_ready = stall_pat[stall_idx % 4];
      stall_idx++;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      check1("in_ready_rule", {31'b0, in_ready}, {31'b0, (~out_valid | out_ready)});
      if (prev_stall) begin
        check1("stall_hold", {28'b0, out_valid, out_i, out_q, out_last},
               {28'b0, 1'b1, prev_out});
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (out_last) last_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got i=%0b q=%0b last=%0b expected none",
                   out_i, out_q, out_last);
        end else begin
          check1("out_symbol", {29'b0, out_i, out_q, out_last}, {29'b0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_out   = {out_i, out_q, out_last};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sample(input logic [23:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", n);
        report();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_symbol(input logic bi, input logic bq, input bit ph_only);
    for (int s = 0; s < DECIM; s++) begin
      if (ph_only && s != SP) push_sample({lvl(~bi), lvl(~bq)});
      else                    push_sample({lvl(bi), lvl(bq)});
    end
  endtask

  task automatic send_raw_symbol(input logic [23:0] d);
    for (int s = 0; s < DECIM; s++) push_sample(d);
  endtask

  task automatic send_header(input logic [31:0] pat, input bit ph_only);
    for (int k = 0; k < HL; k++) send_symbol(pat[2*k+1], pat[2*k], ph_only);
  endtask

  // mode 0: constant I=+1000/Q=-1000; mode 1: varying bit pairs.
  task automatic send_payload(input bit ph_only, input int mode);
    logic bi, bq;
    for (int k = 0; k < PL; k++) begin
      if (mode == 0) begin
        bi = 1'b0; bq = 1'b1;
      end else begin
        bi = k[0] ^ k[2]; bq = k[1];
      end
      exp_q.push_back({bi, bq, (k == PL - 1)});
      send_symbol(bi, bq, ph_only);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
  endtask

  // ---------------- test sequence ----------------
  int base_out, base_last;

  initial begin
    vecs[0] = '{12'h3E8, 12'hC18, 1'b0, 1'b1};
    vecs[1] = '{12'h000, 12'h000, 1'b0, 1'b0};
    vecs[2] = '{12'h7FF, 12'h800, 1'b0, 1'b1};
    vecs[3] = '{12'h800, 12'h7FF, 1'b1, 1'b0};
    vecs[4] = '{12'hFFF, 12'h001, 1'b1, 1'b0};
    vecs[5] = '{12'h001, 12'hFFF, 1'b0, 1'b1};
    vecs[6] = '{12'hC18, 12'hC18, 1'b1, 1'b1};
    vecs[7] = '{12'h3E8, 12'h3E8, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check1("rst_out_i", {31'b0, out_i}, 32'd0);
    check1("rst_out_q", {31'b0, out_q}, 32'd0);
    check1("rst_out_last", {31'b0, out_last}, 32'd0);
    check1("rst_locked", {31'b0, locked}, 32'd0);
    check1("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check1("rst_state", 32'(dbg_state), 32'(HUNT));
    @(posedge clk); #1;

    // Frame 1: header, table-driven demap symbols, then constant payload.
    base_out = out_count; base_last = last_count;
    send_header(HDR, 1'b0);
    check1("f1_locked_rise", {31'b0, locked}, 32'd1);
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back({vecs[v].exp_i, vecs[v].exp_q, 1'b0});
      send_raw_symbol({vecs[v].i_val, vecs[v].q_val});
    end
    for (int k = 8; k < PL; k++) begin
      exp_q.push_back({1'b0, 1'b1, (k == PL - 1)});
      send_symbol(1'b0, 1'b1, 1'b0);
      if (k == 128) check1("f1_locked_mid", {31'b0, locked}, 32'd1);
    end
    wait_drain();
    check1("f1_locked_fall", {31'b0, locked}, 32'd0);
    check1("f1_count", out_count - base_out, PL);
    check1("f1_lasts", last_count - base_last, 32'd1);

    // Header with one bit flipped.
    base_out = out_count; base_last = last_count;
    send_header(HDR ^ 32'h0000_0020, 1'b0);
`ifdef RX_HDR_TOL_EN
    check1("flip_locked_tol", {31'b0, locked}, 32'd1);
    send_payload(1'b0, 0);
    wait_drain();
    check1("flip_count_tol", out_count - base_out, PL);
`else
    check1("flip_locked_exact", {31'b0, locked}, 32'd0);
    for (int k = 0; k < 4; k++) send_symbol(1'b0, 1'b1, 1'b0);
    check1("flip_nolock_after", {31'b0, locked}, 32'd0);
    check1("flip_count_exact", out_count - base_out, 32'd0);
`endif

    // out_ready toggling 1-0-0-1 during a varied payload.
    base_out = out_count; base_last = last_count;
    send_header(HDR, 1'b0);
    check1("stall_locked", {31'b0, locked}, 32'd1);
    stall_idx  = 0;
    stall_mode = 1;
    send_payload(1'b0, 1);
    wait_drain();
    stall_mode = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    check1("stall_count", out_count - base_out, PL);
    check1("stall_lasts", last_count - base_last, 32'd1);

    // Only the ph=4 sample carries the intended sign.
    base_out = out_count;
    send_header(HDR, 1'b1);
    check1("ph_locked", {31'b0, locked}, 32'd1);
    send_payload(1'b1, 1);
    wait_drain();
    check1("ph_count", out_count - base_out, PL);

    // Reset while holding payload symbol 100 in the output register.
    send_header(HDR, 1'b0);
    for (int k = 0; k < 100; k++) begin
      exp_q.push_back({k[0], ~k[0], 1'b0});
      send_symbol(k[0], ~k[0], 1'b0);
    end
    wait_drain();
    out_ready = 1'b0;
    for (int s = 0; s <= SP; s++) push_sample({lvl(1'b1), lvl(1'b1)});
    @(negedge clk);
    check1("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    check1("pre_rst_i", {31'b0, out_i}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check1("mid_rst_i", {31'b0, out_i}, 32'd0);
    check1("mid_rst_q", {31'b0, out_q}, 32'd0);
    check1("mid_rst_last", {31'b0, out_last}, 32'd0);
    check1("mid_rst_locked", {31'b0, locked}, 32'd0);
    check1("mid_rst_state", 32'(dbg_state), 32'(HUNT));
    @(posedge clk); #1;
    out_ready = 1'b1;
    base_out = out_count;
    for (int k = 0; k < 20; k++) send_symbol(1'b0, 1'b1, 1'b0);
    check1("post_rst_nolock", {31'b0, locked}, 32'd0);
    for (int k = 8; k < HL; k++) send_symbol(HDR[2*k+1], HDR[2*k], 1'b0);
    check1("partial_hdr_nolock", {31'b0, locked}, 32'd0);
    check1("post_rst_no_out", out_count - base_out, 32'd0);
    send_header(HDR, 1'b0);
    check1("post_rst_relock", {31'b0, locked}, 32'd1);
    send_payload(1'b0, 0);
    wait_drain();
    check1("post_rst_count", out_count - base_out, PL);

    // Two frames back to back.
    base_out = out_count; base_last = last_count;
    send_header(HDR, 1'b0);
    send_payload(1'b0, 1);
    send_header(HDR, 1'b0);
    check1("b2b_relock", {31'b0, locked}, 32'd1);
    send_payload(1'b0, 0);
    wait_drain();
    check1("b2b_count", out_count - base_out, 2 * PL);
    check1("b2b_lasts", last_count - base_last, 32'd2);
    check1("final_queue", exp_q.size(), 32'd0);

    report();
  end

endmodule
